// File: rtl/clkdiv_bank.sv
// Bank of independent programmable clock dividers with shadowed configuration.
// A new divisor/high-time takes effect only at a period boundary, on disable, or on sync.
module clkdiv_bank #(
  parameter int unsigned CH      = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned DEF_DIV = 201,
  parameter int unsigned DEF_HI  = 101
) (
  input  logic                                   CLK_IN,
  input  logic                                   clr_n,
  input  logic [CH-1:0]                          en,
  input  logic                                   sync,
  input  logic                                   wr_en,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
  input  logic [W-1:0]                           wr_div,
  input  logic [W-1:0]                           wr_hi,
  output logic [CH-1:0]                          CLK_OUT,
  output logic [CH-1:0]                          tick,
  output logic [CH-1:0]                          pend
);

  logic [W-1:0]  r_div_a [CH];
  logic [W-1:0]  r_hi_a  [CH];
  logic [W-1:0]  r_div_s [CH];
  logic [W-1:0]  r_hi_s  [CH];
  logic [W-1:0]  r_cnt   [CH];
  logic [CH-1:0] r_clk;
  logic [CH-1:0] r_tick;
  logic [CH-1:0] r_pend;

  logic [W-1:0]  w_div_a_nx [CH];
  logic [W-1:0]  w_hi_a_nx  [CH];
  logic [W-1:0]  w_div_s_nx [CH];
  logic [W-1:0]  w_hi_s_nx  [CH];
  logic [W-1:0]  w_cnt_nx   [CH];
  logic [CH-1:0] w_hit;
  logic [CH-1:0] w_wrap;
  logic [CH-1:0] w_apply;
  logic [CH-1:0] w_clk_nx;
  logic [CH-1:0] w_tick_nx;
  logic [CH-1:0] w_pend_nx;
  logic [31:0]   w_wr_idx;
  logic          w_wr_ok;

  assign w_wr_idx = 32'(wr_ch);
  assign w_wr_ok  = wr_en && (w_wr_idx < CH);

  always_comb begin
    w_hit     = '0;
    w_wrap    = '0;
    w_apply   = '0;
    w_clk_nx  = '0;
    w_tick_nx = '0;
    w_pend_nx = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      w_hit[i]   = w_wr_ok && (w_wr_idx == i);
      w_wrap[i]  = (r_cnt[i] == r_div_a[i]);
      w_apply[i] = !en[i] || sync || w_wrap[i];
      // A write colliding with an apply bypasses the shadow straight into the active regs.
      w_div_s_nx[i] = w_hit[i] ? wr_div : r_div_s[i];
      w_hi_s_nx[i]  = w_hit[i] ? wr_hi  : r_hi_s[i];
      w_div_a_nx[i] = w_apply[i] ? w_div_s_nx[i] : r_div_a[i];
      w_hi_a_nx[i]  = w_apply[i] ? w_hi_s_nx[i]  : r_hi_a[i];
      w_pend_nx[i]  = !w_apply[i] && (w_hit[i] || r_pend[i]);
      if (!en[i]) begin
        w_cnt_nx[i] = w_div_a_nx[i];
      end else if (sync || w_wrap[i]) begin
        w_cnt_nx[i] = '0;
      end else begin
        w_cnt_nx[i] = r_cnt[i] + W'(1);
      end
      w_tick_nx[i] = en[i] && (sync || w_wrap[i]);
      w_clk_nx[i]  = en[i] && (w_cnt_nx[i] < w_hi_a_nx[i]);
    end
  end

  always_ff @(posedge CLK_IN or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_div_a[i] <= W'(DEF_DIV);
        r_div_s[i] <= W'(DEF_DIV);
        r_hi_a[i]  <= W'(DEF_HI);
        r_hi_s[i]  <= W'(DEF_HI);
        r_cnt[i]   <= W'(DEF_DIV);
      end
      r_clk  <= '0;
      r_tick <= '0;
      r_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_div_a[i] <= w_div_a_nx[i];
        r_div_s[i] <= w_div_s_nx[i];
        r_hi_a[i]  <= w_hi_a_nx[i];
        r_hi_s[i]  <= w_hi_s_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
      r_clk  <= w_clk_nx;
      r_tick <= w_tick_nx;
      r_pend <= w_pend_nx;
    end
  end

  assign CLK_OUT = r_clk;
  assign tick    = r_tick;
  assign pend    = r_pend;

endmodule

// File: tb/tb_clkdiv_bank.sv
// Scoreboard bench for clkdiv_bank: per-cycle expected {tick, CLK_OUT, pend} derived
// from period/high-time arithmetic, queued as stimulus is driven and popped after each edge.
module tb_clkdiv_bank;

  logic        CLK_IN = 1'b0;
  logic        clr_n;
  logic [3:0]  en;
  logic        sync;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [31:0] wr_div;
  logic [31:0] wr_hi;
  logic [3:0]  CLK_OUT;
  logic [3:0]  tick;
  logic [3:0]  pend;

  typedef struct {
    logic [3:0] tck;
    logic [3:0] clk;
    logic [3:0] pnd;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  clkdiv_bank #(.CH(4), .W(32), .DEF_DIV(201), .DEF_HI(101)) dut (
    .CLK_IN (CLK_IN),
    .clr_n  (clr_n),
    .en     (en),
    .sync   (sync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .wr_hi  (wr_hi),
    .CLK_OUT(CLK_OUT),
    .tick   (tick),
    .pend   (pend)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic cyc();
    @(posedge CLK_IN);
    @(negedge CLK_IN);
  endtask

  task automatic apply_reset();
    @(negedge CLK_IN);
    clr_n = 1'b0; en = 4'b0000; sync = 1'b0; wr_en = 1'b0;
    wr_ch = 2'd0; wr_div = 32'd0; wr_hi = 32'd0;
    cyc();
    cyc();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [31:0] dv, input logic [31:0] hi);
    wr_en = 1'b1; wr_ch = ch; wr_div = dv; wr_hi = hi;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({tick, CLK_OUT, pend} !== 12'h000) begin
      errors++;
      $display("FAIL reset: got tick=%b clk=%b pend=%b, want all 0", tick, CLK_OUT, pend);
    end
  endtask

  task automatic test_defaults();
    exp_t e, g;
    apply_reset();
    for (int k = 0; k < 405; k++) begin
      if (k == 0) begin clr_n = 1'b1; en = 4'b0001; end
      e.tck = {3'b000, (k % 202) == 0};
      e.clk = {3'b000, (k % 202) < 101};
      e.pnd = 4'b0000;
      sbq.push_back(e);
      cyc();
      g = sbq.pop_front();
      checks++;
      if ({tick, CLK_OUT, pend} !== {g.tck, g.clk, g.pnd}) begin
        errors++;
        $display("FAIL defaults k=%0d: got t/c/p=%b/%b/%b want %b/%b/%b",
                 k, tick, CLK_OUT, pend, g.tck, g.clk, g.pnd);
      end
    end
  endtask

  task automatic test_reconfig();
    exp_t e, g;
    int p;
    apply_reset();
    for (int k = 0; k < 240; k++) begin
      if (k == 0) begin clr_n = 1'b1; en = 4'b0001; end
      if (k == 50) begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 32'd9; wr_hi = 32'd3; end
      else wr_en = 1'b0;
      p = (k < 202) ? k : (k - 202) % 10;
      e.tck = {3'b000, p == 0};
      e.clk = {3'b000, (k < 202) ? (p < 101) : (p < 3)};
      e.pnd = {3'b000, (k >= 50) && (k < 202)};
      sbq.push_back(e);
      cyc();
      g = sbq.pop_front();
      checks++;
      if ({tick, CLK_OUT, pend} !== {g.tck, g.clk, g.pnd}) begin
        errors++;
        $display("FAIL reconfig k=%0d: got t/c/p=%b/%b/%b want %b/%b/%b",
                 k, tick, CLK_OUT, pend, g.tck, g.clk, g.pnd);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_edges();
    exp_t e, g;
    logic e2;
    int p2;
    apply_reset();
    clr_n = 1'b1;
    cyc();
    cfg(2'd1, 32'd201, 32'd0);
    cfg(2'd2, 32'd9, 32'd20);
    cfg(2'd3, 32'd0, 32'd1);
    checks++;
    if ({tick, CLK_OUT, pend} !== 12'h000) begin
      errors++;
      $display("FAIL edges_disabled_write: got t/c/p=%b/%b/%b want 0/0/0", tick, CLK_OUT, pend);
    end
    for (int k = 0; k < 46; k++) begin
      e2 = !((k >= 25) && (k < 28));
      en = {1'b1, e2, 1'b1, 1'b0};
      p2 = (k < 25) ? k : k - 28;
      e.tck = {1'b1, e2 && ((p2 % 10) == 0), (k % 202) == 0, 1'b0};
      e.clk = {1'b1, e2, 1'b0, 1'b0};
      e.pnd = 4'b0000;
      sbq.push_back(e);
      cyc();
      g = sbq.pop_front();
      checks++;
      if ({tick, CLK_OUT, pend} !== {g.tck, g.clk, g.pnd}) begin
        errors++;
        $display("FAIL edges k=%0d: got t/c/p=%b/%b/%b want %b/%b/%b",
                 k, tick, CLK_OUT, pend, g.tck, g.clk, g.pnd);
      end
    end
  endtask

  task automatic test_sync();
    exp_t e, g;
    int p;
    apply_reset();
    clr_n = 1'b1;
    cyc();
    cfg(2'd0, 32'd9, 32'd5);
    cfg(2'd1, 32'd4, 32'd2);
    for (int k = 0; k < 31; k++) begin
      en = 4'b0011;
      sync = (k == 7);
      p = (k < 7) ? k : k - 7;
      e.tck = {2'b00, (p % 5) == 0, (p % 10) == 0};
      e.clk = {2'b00, (p % 5) < 2, (p % 10) < 5};
      e.pnd = 4'b0000;
      sbq.push_back(e);
      cyc();
      g = sbq.pop_front();
      checks++;
      if ({tick, CLK_OUT, pend} !== {g.tck, g.clk, g.pnd}) begin
        errors++;
        $display("FAIL sync k=%0d: got t/c/p=%b/%b/%b want %b/%b/%b",
                 k, tick, CLK_OUT, pend, g.tck, g.clk, g.pnd);
      end
    end
    sync = 1'b0;
  endtask

  task automatic test_collision();
    exp_t e, g;
    int p;
    apply_reset();
    clr_n = 1'b1;
    cyc();
    cfg(2'd0, 32'd9, 32'd3);
    for (int k = 0; k < 37; k++) begin
      en = 4'b0001;
      wr_en = 1'b0;
      if (k == 20) begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 32'd4; wr_hi = 32'd2; end
      if (k == 36) begin wr_en = 1'b1; wr_ch = 2'd0; wr_div = 32'd7; wr_hi = 32'd1; end
      p = (k < 20) ? (k % 10) : ((k - 20) % 5);
      e.tck = {3'b000, p == 0};
      e.clk = {3'b000, (k < 20) ? (p < 3) : (p < 2)};
      e.pnd = {3'b000, k == 36};
      sbq.push_back(e);
      cyc();
      g = sbq.pop_front();
      checks++;
      if ({tick, CLK_OUT, pend} !== {g.tck, g.clk, g.pnd}) begin
        errors++;
        $display("FAIL collision k=%0d: got t/c/p=%b/%b/%b want %b/%b/%b",
                 k, tick, CLK_OUT, pend, g.tck, g.clk, g.pnd);
      end
    end
    wr_en = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({tick, CLK_OUT, pend} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got t/c/p=%b/%b/%b want 0/0/0", tick, CLK_OUT, pend);
    end
    @(negedge CLK_IN);
    for (int k = 0; k < 204; k++) begin
      if (k == 0) clr_n = 1'b1;
      e.tck = {3'b000, (k % 202) == 0};
      e.clk = {3'b000, (k % 202) < 101};
      e.pnd = 4'b0000;
      sbq.push_back(e);
      cyc();
      g = sbq.pop_front();
      checks++;
      if ({tick, CLK_OUT, pend} !== {g.tck, g.clk, g.pnd}) begin
        errors++;
        $display("FAIL post_reset k=%0d: got t/c/p=%b/%b/%b want %b/%b/%b",
                 k, tick, CLK_OUT, pend, g.tck, g.clk, g.pnd);
      end
    end
  endtask

  initial begin
    clr_n = 1'b0; en = 4'b0000; sync = 1'b0; wr_en = 1'b0;
    wr_ch = 2'd0; wr_div = 32'd0; wr_hi = 32'd0;
    test_reset();
    test_defaults();
    test_reconfig();
    test_edges();
    test_sync();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter W, default 32, meaning the counter and divisor width in bits (≥2).
REQ-003 SHALL have parameter DEF_DIV, default 201, meaning the reset terminal count; period = DEF_DIV+1 cycles.
REQ-004 SHALL have parameter DEF_HI, default 101, meaning the reset high-time in cycles.
REQ-005 SHALL have port CLK_IN  input  1  single clock; all logic is on its rising edge.
REQ-006 SHALL have port clr_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port en  input  CH  per-channel run enable.
REQ-008 SHALL have port sync  input  1  one-cycle pulse that restarts all enabled channels in phase.
REQ-009 SHALL have port wr_en  input  1  config write strobe.
REQ-010 SHALL have port wr_ch  input  clog2(CH) (min 1)  target channel of the write.
REQ-011 SHALL have port wr_div  input  W  new terminal count.
REQ-012 SHALL have port wr_hi  input  W  new high-time.
REQ-013 SHALL have port CLK_OUT  output  CH  registered divided clocks.
REQ-014 SHALL have port tick  output  CH  registered one-cycle pulse at each period start.
REQ-015 SHALL have port pend  output  CH  shadow config not yet applied.

Function
REQ-016 Each channel SHALL hold the active regs div_a and hi_a, the shadows div_s and hi_s, a counter cnt[W-1:0] and a pend flag.
REQ-017 Write: wr_en=1 with wr_ch<CH SHALL load div_s/hi_s of wr_ch and set its pend flag; a write with wr_ch≥CH SHALL be ignored.
REQ-018 Enabled cycle: cnt_next = (cnt==div_a) ? 0 : cnt+1.
REQ-019 Wrap: when cnt_next=0 from a wrap, tick SHALL be 1 on the next cycle, otherwise tick SHALL be 0.
REQ-020 CLK_OUT[i] next SHALL be (cnt_next < hi_a_next), evaluated after any apply in the same cycle.
REQ-021 The output SHALL therefore be high for hi cycles and low for div+1−hi cycles per period.
REQ-022 Apply: div_a/hi_a SHALL take the shadows and pend SHALL clear whenever the channel wraps, is disabled, or sync=1.
REQ-023 Apply SHALL never occur mid-period, so the output SHALL have no runt or glitch pulses.
REQ-024 Write and apply in the same cycle on the same channel: the written wr_div/wr_hi SHALL go directly to the active regs, and pend SHALL end at 0.
REQ-025 Disabled (en[i]=0): cnt SHALL be held at div_a_next (terminal) and CLK_OUT[i]=0, tick[i]=0.
REQ-026 The first enabled cycle SHALL therefore wrap: tick=1 and a full first period starts at cnt=0.
REQ-027 Re-enable after disable SHALL behave identically to the first enable.
REQ-028 sync=1: every enabled channel SHALL force cnt_next=0, apply shadows, and pulse tick; disabled channels SHALL be unaffected except for the shadow apply.
REQ-029 Boundary values:
- hi_a=0 → CLK_OUT constantly 0.
- hi_a>div_a → CLK_OUT constantly 1.
- div_a=0 → period 1 cycle, and tick SHALL be 1 every enabled cycle.
REQ-030 Counter compare and increment SHALL be unsigned W-bit; cnt SHALL never exceed div_a, including after div_a shrinks (a shrink is only applied at wrap, so this holds).
REQ-031 Channels SHALL be fully independent; a simultaneous wrap on all channels SHALL be legal.

Reset
REQ-032 clr_n=0 SHALL asynchronously set, per channel:
- div_a=div_s=DEF_DIV, hi_a=hi_s=DEF_HI
- cnt=DEF_DIV, pend=0
- CLK_OUT=0, tick=0
REQ-033 Reset asserted mid-period SHALL discard the counter state and pending shadows immediately; after release each enabled channel SHALL restart per REQ-026.
REQ-034 Release SHALL be sampled on CLK_IN; the first active edge after release SHALL be the first counted cycle.

Verification
REQ-035 Defaults, CH=4, W=32: release reset, en=0001 → tick[0] every 202 cycles; CLK_OUT[0] high 101 / low 101; other bits stay 0.
REQ-036 Reconfig: write ch0 div=9 hi=3 mid-period → pend[0]=1 until the current 202-cycle period ends; then period 10, high 3; pend[0]=0.
REQ-037 Edge values: ch1 hi=0 → constant low; ch2 hi=20 with div=9 → constant high; ch3 div=0 hi=1 → tick every cycle, CLK_OUT high.
REQ-038 Sync: ch0 div=9 and ch1 div=4, free-running, pulse sync → both tick on the next cycle, then ch1 ticks at +5 and +10 while ch0 ticks at +10.
REQ-039 Collision: write ch0 on exactly the wrap cycle → new values active in the immediately following period, pend[0]=0; clr_n low mid-period → all outputs 0 at once.
